// File: rtl/set_on_pkg.sv
// rtl/set_on_pkg.sv - op encodings, FSM state type and result helpers for set_on_iter
package set_on_pkg;

    // RISC-V branch funct3 compare encodings
    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b100;
    localparam logic [2:0] OP_GE  = 3'b101;
    localparam logic [2:0] OP_LTU = 3'b110;
    localparam logic [2:0] OP_GEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed compares are done unsigned after flipping the sign bit of the top chunk
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_LT) || (op == OP_GE);
    endfunction

    // Fold the magnitude flags into the boolean answer; reserved ops answer 0
    function automatic logic op_eval(input logic [2:0] op, input logic lt, input logic gt);
        logic r;
        case (op)
            OP_EQ:          r = !lt && !gt;
            OP_NE:          r = lt || gt;
            OP_LT, OP_LTU:  r = lt;
            OP_GE, OP_GEU:  r = !lt;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/set_on_iter_cmp_chunk.sv
// rtl/set_on_iter_cmp_chunk.sv - combinational unsigned compare of one chunk
module cmp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt,
    output logic             gt
);

    // lt and gt are mutually exclusive; both low means the chunks are equal
    always_comb begin
        lt = (a < b);
        gt = (a > b);
    end

endmodule

// File: rtl/set_on_iter.sv
// rtl/set_on_iter.sv - multi-cycle chunk-serial compare producing a 0/1 set-on result
module set_on_iter #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    import set_on_pkg::*;

    localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCH        = WIDTH / SAFE_CHUNK;
    localparam int IDXW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NCH - 1);
    localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

    if ((CHUNK < 1) || ((WIDTH % SAFE_CHUNK) != 0)) begin : g_param_check
        $error("set_on_iter: WIDTH must be a positive multiple of CHUNK");
    end

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [2:0]        op_q;
    logic              lt_q;
    logic              gt_q;
    logic              last_q;
    logic [IDXW-1:0]   idx_q;
    logic              result_q;

    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic              c_lt;
    logic              c_gt;
    logic              fresh;
    logic              scan_stop;

    // Pick the chunk under scan; the top chunk gets its sign bit flipped for signed ops
    always_comb begin
        a_chunk = a_q[CHUNK*int'(idx_q) +: CHUNK];
        b_chunk = b_q[CHUNK*int'(idx_q) +: CHUNK];
        if (op_is_signed(op_q) && (idx_q == IDX_TOP)) begin
            a_chunk = a_chunk ^ MSB_MASK;
            b_chunk = b_chunk ^ MSB_MASK;
        end
    end

    cmp_chunk #(.CHUNK(CHUNK)) u_cmp_chunk (
        .a  (a_chunk),
        .b  (b_chunk),
        .lt (c_lt),
        .gt (c_gt)
    );

    // No chunk has differed yet, so this chunk's verdict decides; stop after chunk 0 or early
    always_comb begin
        fresh     = !lt_q && !gt_q;
        scan_stop = (idx_q == '0) || ((EARLY_EXIT != 0) && fresh && (c_lt || c_gt));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: last_q marks that the flags are final and the result latches on this edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SCAN;
            SCAN:    if (last_q)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == SCAN) || (state_q == DONE);
        result    = WIDTH'(result_q);
    end

    // Datapath: capture operands, walk chunks MSB-first, latch result on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            lt_q     <= 1'b0;
            gt_q     <= 1'b0;
            last_q   <= 1'b0;
            idx_q    <= '0;
            result_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= alu_a;
                        b_q    <= alu_b;
                        op_q   <= op;
                        lt_q   <= 1'b0;
                        gt_q   <= 1'b0;
                        last_q <= 1'b0;
                        idx_q  <= IDX_TOP;
                    end
                end
                SCAN: begin
                    if (last_q) begin
                        result_q <= op_eval(op_q, lt_q, gt_q);
                        last_q   <= 1'b0;
                    end else begin
                        if (fresh) begin
                            lt_q <= c_lt;
                            gt_q <= c_gt;
                        end
                        if (scan_stop) begin
                            last_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_set_on_iter.sv
// tb/tb_set_on_iter.sv - self-checking bench for set_on_iter (EARLY_EXIT 0 and 1)
module tb_set_on_iter;

    localparam int W   = 32;
    localparam int C   = 8;
    localparam int NCH = W / C;

    localparam logic [2:0] EQ = 3'b000, NE = 3'b001, LT = 3'b100, GE = 3'b101;
    localparam logic [2:0] LTU = 3'b110, GEU = 3'b111, RSV = 3'b010;

    logic clk = 1'b0;
    logic rst_n;

    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [2:0]   op        [2];
    logic [W-1:0] alu_a     [2];
    logic [W-1:0] alu_b     [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [W-1:0] result    [2];
    logic         busy      [2];

    logic         m_busy  [2];
    logic         m_valid [2];
    logic [W-1:0] m_res   [2];
    logic [W-1:0] m_pend  [2];
    int           m_cnt   [2];
    int           m_lat   [2];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_cmp(input logic [2:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (o)
            EQ:      return W'(a == b);
            NE:      return W'(a != b);
            LT:      return W'($signed(a) < $signed(b));
            GE:      return W'($signed(a) >= $signed(b));
            LTU:     return W'(a < b);
            GEU:     return W'(a >= b);
            default: return '0;
        endcase
    endfunction

    // Chunks the scan visits: all of them, or down to the highest differing byte
    function automatic int scan_len(input logic [W-1:0] a, input logic [W-1:0] b, input int ee);
        if (ee == 0) return NCH;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (((a >> (C * j)) & 32'hFF) != ((b >> (C * j)) & 32'hFF)) return NCH - j;
        end
        return NCH;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        set_on_iter #(.WIDTH(W), .CHUNK(C), .EARLY_EXIT(g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .op        (op[g]),
            .alu_a     (alu_a[g]),
            .alu_b     (alu_b[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .result    (result[g]),
            .busy      (busy[g])
        );

        // Transaction model: answer from arithmetic, valid k+1 edges after accept
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_busy[g]  <= 1'b0;
                m_valid[g] <= 1'b0;
                m_res[g]   <= '0;
                m_pend[g]  <= '0;
                m_cnt[g]   <= 0;
                m_lat[g]   <= 0;
            end else if (!m_busy[g]) begin
                if (in_valid[g]) begin
                    m_busy[g] <= 1'b1;
                    m_cnt[g]  <= 0;
                    m_lat[g]  <= scan_len(alu_a[g], alu_b[g], g);
                    m_pend[g] <= ref_cmp(op[g], alu_a[g], alu_b[g]);
                end
            end else if (!m_valid[g]) begin
                if (m_cnt[g] == m_lat[g]) begin
                    m_valid[g] <= 1'b1;
                    m_res[g]   <= m_pend[g];
                end else begin
                    m_cnt[g] <= m_cnt[g] + 1;
                end
            end else if (out_ready[g]) begin
                m_valid[g] <= 1'b0;
                m_busy[g]  <= 1'b0;
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d in_ready", i),  W'(in_ready[i]),  W'(!m_busy[i]));
            check($sformatf("dut%0d busy", i),      W'(busy[i]),      W'(m_busy[i]));
            check($sformatf("dut%0d out_valid", i), W'(out_valid[i]), W'(m_valid[i]));
            check($sformatf("dut%0d result", i),    result[i],        m_res[i]);
        end
    end

    // Issue one op, check literal latency/result, optionally stall the consumer
    task automatic run_op(input int d, input string name, input logic [2:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input int exp_lat, input int hold);
        int lat;
        bit seen;
        @(posedge clk); #2;
        check({name, " ready before issue"}, W'(in_ready[d]), W'(1));
        out_ready[d] = (hold == 0);
        in_valid[d]  = 1'b1;
        op[d]        = o;
        alu_a[d]     = a;
        alu_b[d]     = b;
        @(posedge clk); #2;
        in_valid[d] = 1'b0;
        op[d]       = ~o;
        alu_a[d]    = ~a;
        alu_b[d]    = a;
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid[d]) seen = 1'b1;
        end
        check({name, " latency"}, W'(seen ? lat : -1), W'(exp_lat));
        check({name, " result"}, result[d], exp_res);
        if (hold > 0) begin
            in_valid[d] = 1'b1;
            op[d]       = EQ;
            alu_a[d]    = '0;
            alu_b[d]    = '0;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                check({name, " stall out_valid"}, W'(out_valid[d]), W'(1));
                check({name, " stall result"},    result[d],        exp_res);
                check({name, " stall in_ready"},  W'(in_ready[d]),  W'(0));
            end
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end
        @(posedge clk); #1;
        check({name, " back to idle"}, W'(in_ready[d]), W'(1));
        check({name, " result held"},  result[d],       exp_res);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            op[i]        = '0;
            alu_a[i]     = '0;
            alu_b[i]     = '0;
            out_ready[i] = 1'b1;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            check("reset in_ready",  W'(in_ready[i]),  W'(1));
            check("reset out_valid", W'(out_valid[i]), W'(0));
            check("reset busy",      W'(busy[i]),      W'(0));
            check("reset result",    result[i],        W'(0));
        end
        rst_n = 1'b1;

        run_op(0, "lt_neg",   LT,  32'hFFFF_FFFF, 32'h0000_0001, 1, NCH + 1, 0);
        run_op(0, "ltu_big",  LTU, 32'hFFFF_FFFF, 32'h0000_0001, 0, NCH + 1, 0);
        run_op(0, "ge_min",   GE,  32'h8000_0000, 32'h7FFF_FFFF, 0, NCH + 1, 0);
        run_op(0, "geu_min",  GEU, 32'h8000_0000, 32'h7FFF_FFFF, 1, NCH + 1, 0);
        run_op(0, "eq_same",  EQ,  32'h1234_5678, 32'h1234_5678, 1, 5, 0);
        run_op(0, "rsv_op",   RSV, 32'h0000_0001, 32'h0000_0002, 0, 5, 0);
        run_op(0, "ne_same",  NE,  32'h1234_5678, 32'h1234_5678, 0, 5, 0);
        run_op(0, "lt_low",   LT,  32'h0000_0010, 32'h0000_0011, 1, 5, 0);
        run_op(0, "geu_hold", GEU, 32'h0000_0005, 32'h0000_0003, 1, 5, 3);

        // Reset during the second SCAN cycle discards the operation
        @(posedge clk); #2;
        in_valid[0] = 1'b1;
        op[0]       = NE;
        alu_a[0]    = 32'h0000_0001;
        alu_b[0]    = 32'h0000_0000;
        @(posedge clk); #2;
        in_valid[0] = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst mid out_valid", W'(out_valid[0]), W'(0));
        check("rst mid result",    result[0],        W'(0));
        check("rst mid in_ready",  W'(in_ready[0]),  W'(1));
        check("rst mid busy",      W'(busy[0]),      W'(0));
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("no stale out_valid", W'(out_valid[0]), W'(0));
        end

        run_op(1, "ee_ltu_top", LTU, 32'h0100_0000, 32'h0000_0000, 0, 2, 0);
        run_op(1, "ee_lt_neg",  LT,  32'hFFFF_FFFF, 32'h0000_0001, 1, 2, 0);
        run_op(1, "ee_eq",      EQ,  32'hCAFE_F00D, 32'hCAFE_F00D, 1, NCH + 1, 0);
        run_op(1, "ee_ltu_b1",  LTU, 32'h0000_0100, 32'h0000_0200, 1, 4, 0);
        run_op(1, "ee_ge_b0",   GE,  32'h0000_0007, 32'h0000_0009, 0, 5, 0);
        run_op(0, "after_rst",  GEU, 32'h0000_0009, 32'h0000_0007, 1, 5, 0);

        #20;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
